// File: rtl/aes_dec_pkg.sv
// Shared AES decryption definitions: state geometry, FSM encoding, byte addressing.
// Pure declarations; no logic, no latency, no flow control.
// Byte index follows the column-major AES state layout (byte = 4*col + row).
package aes_dec_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } isb_state_e;

    function automatic int byte_idx(input int row, input int col);
        return 4 * col + row;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box as a 256-entry combinational lookup.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Table row n holds inputs 8'hn0..8'hnf, eight entries per source line.
module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_byte)
            8'h00: o_byte = 8'h52; 8'h01: o_byte = 8'h09; 8'h02: o_byte = 8'h6a; 8'h03: o_byte = 8'hd5; 8'h04: o_byte = 8'h30; 8'h05: o_byte = 8'h36; 8'h06: o_byte = 8'ha5; 8'h07: o_byte = 8'h38;
            8'h08: o_byte = 8'hbf; 8'h09: o_byte = 8'h40; 8'h0a: o_byte = 8'ha3; 8'h0b: o_byte = 8'h9e; 8'h0c: o_byte = 8'h81; 8'h0d: o_byte = 8'hf3; 8'h0e: o_byte = 8'hd7; 8'h0f: o_byte = 8'hfb;
            8'h10: o_byte = 8'h7c; 8'h11: o_byte = 8'he3; 8'h12: o_byte = 8'h39; 8'h13: o_byte = 8'h82; 8'h14: o_byte = 8'h9b; 8'h15: o_byte = 8'h2f; 8'h16: o_byte = 8'hff; 8'h17: o_byte = 8'h87;
            8'h18: o_byte = 8'h34; 8'h19: o_byte = 8'h8e; 8'h1a: o_byte = 8'h43; 8'h1b: o_byte = 8'h44; 8'h1c: o_byte = 8'hc4; 8'h1d: o_byte = 8'hde; 8'h1e: o_byte = 8'he9; 8'h1f: o_byte = 8'hcb;
            8'h20: o_byte = 8'h54; 8'h21: o_byte = 8'h7b; 8'h22: o_byte = 8'h94; 8'h23: o_byte = 8'h32; 8'h24: o_byte = 8'ha6; 8'h25: o_byte = 8'hc2; 8'h26: o_byte = 8'h23; 8'h27: o_byte = 8'h3d;
            8'h28: o_byte = 8'hee; 8'h29: o_byte = 8'h4c; 8'h2a: o_byte = 8'h95; 8'h2b: o_byte = 8'h0b; 8'h2c: o_byte = 8'h42; 8'h2d: o_byte = 8'hfa; 8'h2e: o_byte = 8'hc3; 8'h2f: o_byte = 8'h4e;
            8'h30: o_byte = 8'h08; 8'h31: o_byte = 8'h2e; 8'h32: o_byte = 8'ha1; 8'h33: o_byte = 8'h66; 8'h34: o_byte = 8'h28; 8'h35: o_byte = 8'hd9; 8'h36: o_byte = 8'h24; 8'h37: o_byte = 8'hb2;
            8'h38: o_byte = 8'h76; 8'h39: o_byte = 8'h5b; 8'h3a: o_byte = 8'ha2; 8'h3b: o_byte = 8'h49; 8'h3c: o_byte = 8'h6d; 8'h3d: o_byte = 8'h8b; 8'h3e: o_byte = 8'hd1; 8'h3f: o_byte = 8'h25;
            8'h40: o_byte = 8'h72; 8'h41: o_byte = 8'hf8; 8'h42: o_byte = 8'hf6; 8'h43: o_byte = 8'h64; 8'h44: o_byte = 8'h86; 8'h45: o_byte = 8'h68; 8'h46: o_byte = 8'h98; 8'h47: o_byte = 8'h16;
            8'h48: o_byte = 8'hd4; 8'h49: o_byte = 8'ha4; 8'h4a: o_byte = 8'h5c; 8'h4b: o_byte = 8'hcc; 8'h4c: o_byte = 8'h5d; 8'h4d: o_byte = 8'h65; 8'h4e: o_byte = 8'hb6; 8'h4f: o_byte = 8'h92;
            8'h50: o_byte = 8'h6c; 8'h51: o_byte = 8'h70; 8'h52: o_byte = 8'h48; 8'h53: o_byte = 8'h50; 8'h54: o_byte = 8'hfd; 8'h55: o_byte = 8'hed; 8'h56: o_byte = 8'hb9; 8'h57: o_byte = 8'hda;
            8'h58: o_byte = 8'h5e; 8'h59: o_byte = 8'h15; 8'h5a: o_byte = 8'h46; 8'h5b: o_byte = 8'h57; 8'h5c: o_byte = 8'ha7; 8'h5d: o_byte = 8'h8d; 8'h5e: o_byte = 8'h9d; 8'h5f: o_byte = 8'h84;
            8'h60: o_byte = 8'h90; 8'h61: o_byte = 8'hd8; 8'h62: o_byte = 8'hab; 8'h63: o_byte = 8'h00; 8'h64: o_byte = 8'h8c; 8'h65: o_byte = 8'hbc; 8'h66: o_byte = 8'hd3; 8'h67: o_byte = 8'h0a;
            8'h68: o_byte = 8'hf7; 8'h69: o_byte = 8'he4; 8'h6a: o_byte = 8'h58; 8'h6b: o_byte = 8'h05; 8'h6c: o_byte = 8'hb8; 8'h6d: o_byte = 8'hb3; 8'h6e: o_byte = 8'h45; 8'h6f: o_byte = 8'h06;
            8'h70: o_byte = 8'hd0; 8'h71: o_byte = 8'h2c; 8'h72: o_byte = 8'h1e; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'hca; 8'h75: o_byte = 8'h3f; 8'h76: o_byte = 8'h0f; 8'h77: o_byte = 8'h02;
            8'h78: o_byte = 8'hc1; 8'h79: o_byte = 8'haf; 8'h7a: o_byte = 8'hbd; 8'h7b: o_byte = 8'h03; 8'h7c: o_byte = 8'h01; 8'h7d: o_byte = 8'h13; 8'h7e: o_byte = 8'h8a; 8'h7f: o_byte = 8'h6b;
            8'h80: o_byte = 8'h3a; 8'h81: o_byte = 8'h91; 8'h82: o_byte = 8'h11; 8'h83: o_byte = 8'h41; 8'h84: o_byte = 8'h4f; 8'h85: o_byte = 8'h67; 8'h86: o_byte = 8'hdc; 8'h87: o_byte = 8'hea;
            8'h88: o_byte = 8'h97; 8'h89: o_byte = 8'hf2; 8'h8a: o_byte = 8'hcf; 8'h8b: o_byte = 8'hce; 8'h8c: o_byte = 8'hf0; 8'h8d: o_byte = 8'hb4; 8'h8e: o_byte = 8'he6; 8'h8f: o_byte = 8'h73;
            8'h90: o_byte = 8'h96; 8'h91: o_byte = 8'hac; 8'h92: o_byte = 8'h74; 8'h93: o_byte = 8'h22; 8'h94: o_byte = 8'he7; 8'h95: o_byte = 8'had; 8'h96: o_byte = 8'h35; 8'h97: o_byte = 8'h85;
            8'h98: o_byte = 8'he2; 8'h99: o_byte = 8'hf9; 8'h9a: o_byte = 8'h37; 8'h9b: o_byte = 8'he8; 8'h9c: o_byte = 8'h1c; 8'h9d: o_byte = 8'h75; 8'h9e: o_byte = 8'hdf; 8'h9f: o_byte = 8'h6e;
            8'ha0: o_byte = 8'h47; 8'ha1: o_byte = 8'hf1; 8'ha2: o_byte = 8'h1a; 8'ha3: o_byte = 8'h71; 8'ha4: o_byte = 8'h1d; 8'ha5: o_byte = 8'h29; 8'ha6: o_byte = 8'hc5; 8'ha7: o_byte = 8'h89;
            8'ha8: o_byte = 8'h6f; 8'ha9: o_byte = 8'hb7; 8'haa: o_byte = 8'h62; 8'hab: o_byte = 8'h0e; 8'hac: o_byte = 8'haa; 8'had: o_byte = 8'h18; 8'hae: o_byte = 8'hbe; 8'haf: o_byte = 8'h1b;
            8'hb0: o_byte = 8'hfc; 8'hb1: o_byte = 8'h56; 8'hb2: o_byte = 8'h3e; 8'hb3: o_byte = 8'h4b; 8'hb4: o_byte = 8'hc6; 8'hb5: o_byte = 8'hd2; 8'hb6: o_byte = 8'h79; 8'hb7: o_byte = 8'h20;
            8'hb8: o_byte = 8'h9a; 8'hb9: o_byte = 8'hdb; 8'hba: o_byte = 8'hc0; 8'hbb: o_byte = 8'hfe; 8'hbc: o_byte = 8'h78; 8'hbd: o_byte = 8'hcd; 8'hbe: o_byte = 8'h5a; 8'hbf: o_byte = 8'hf4;
            8'hc0: o_byte = 8'h1f; 8'hc1: o_byte = 8'hdd; 8'hc2: o_byte = 8'ha8; 8'hc3: o_byte = 8'h33; 8'hc4: o_byte = 8'h88; 8'hc5: o_byte = 8'h07; 8'hc6: o_byte = 8'hc7; 8'hc7: o_byte = 8'h31;
            8'hc8: o_byte = 8'hb1; 8'hc9: o_byte = 8'h12; 8'hca: o_byte = 8'h10; 8'hcb: o_byte = 8'h59; 8'hcc: o_byte = 8'h27; 8'hcd: o_byte = 8'h80; 8'hce: o_byte = 8'hec; 8'hcf: o_byte = 8'h5f;
            8'hd0: o_byte = 8'h60; 8'hd1: o_byte = 8'h51; 8'hd2: o_byte = 8'h7f; 8'hd3: o_byte = 8'ha9; 8'hd4: o_byte = 8'h19; 8'hd5: o_byte = 8'hb5; 8'hd6: o_byte = 8'h4a; 8'hd7: o_byte = 8'h0d;
            8'hd8: o_byte = 8'h2d; 8'hd9: o_byte = 8'he5; 8'hda: o_byte = 8'h7a; 8'hdb: o_byte = 8'h9f; 8'hdc: o_byte = 8'h93; 8'hdd: o_byte = 8'hc9; 8'hde: o_byte = 8'h9c; 8'hdf: o_byte = 8'hef;
            8'he0: o_byte = 8'ha0; 8'he1: o_byte = 8'he0; 8'he2: o_byte = 8'h3b; 8'he3: o_byte = 8'h4d; 8'he4: o_byte = 8'hae; 8'he5: o_byte = 8'h2a; 8'he6: o_byte = 8'hf5; 8'he7: o_byte = 8'hb0;
            8'he8: o_byte = 8'hc8; 8'he9: o_byte = 8'heb; 8'hea: o_byte = 8'hbb; 8'heb: o_byte = 8'h3c; 8'hec: o_byte = 8'h83; 8'hed: o_byte = 8'h53; 8'hee: o_byte = 8'h99; 8'hef: o_byte = 8'h61;
            8'hf0: o_byte = 8'h17; 8'hf1: o_byte = 8'h2b; 8'hf2: o_byte = 8'h04; 8'hf3: o_byte = 8'h7e; 8'hf4: o_byte = 8'hba; 8'hf5: o_byte = 8'h77; 8'hf6: o_byte = 8'hd6; 8'hf7: o_byte = 8'h26;
            8'hf8: o_byte = 8'he1; 8'hf9: o_byte = 8'h69; 8'hfa: o_byte = 8'h14; 8'hfb: o_byte = 8'h63; 8'hfc: o_byte = 8'h55; 8'hfd: o_byte = 8'h21; 8'hfe: o_byte = 8'h0c; 8'hff: o_byte = 8'h7d;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: BYTES_PER_CYCLE shared inverse S-boxes walk the 16-byte state.
// Latency: 16/BYTES_PER_CYCLE cycles from acceptance to out_valid; one block in flight.
// Backpressure: in_ready low while BUSY/DONE; result held until out_ready. INV_SUB_BYTES_FUSED_SHIFT_EN folds InvShiftRows into capture.
module inv_sub_bytes_iter
    import aes_dec_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:AES_STATE_W-1] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:AES_STATE_W-1] out_state,
    output logic                   busy
);

    localparam int NCYC  = AES_NBYTES / BYTES_PER_CYCLE;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    isb_state_e             r_state;
    isb_state_e             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [0:AES_STATE_W-1] r_work;
    logic [0:AES_STATE_W-1] w_work_nxt;
    logic [0:AES_STATE_W-1] w_cap;
    logic [0:AES_STATE_W-1] r_out_state;
    logic                   r_out_valid;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   w_accept;
    logic                   w_last;
    logic [7:0]             w_sb_in  [BYTES_PER_CYCLE];
    logic [7:0]             w_sb_out [BYTES_PER_CYCLE];

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign busy      = r_busy;

    assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
    assign w_last   = (r_cnt == LAST_CNT);

`ifdef INV_SUB_BYTES_FUSED_SHIFT_EN
    // Row r is rotated right by r columns, undoing the encrypt-side ShiftRows.
    always_comb begin
        w_cap = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                w_cap[byte_idx(row, col)*AES_BYTE_W +: AES_BYTE_W] =
                    in_state[byte_idx(row, (col - row + 4) % 4)*AES_BYTE_W +: AES_BYTE_W];
            end
        end
    end
`else
    assign w_cap = in_state;
`endif

    always_comb begin
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            w_sb_in[g] = r_work[(int'(r_cnt) * BYTES_PER_CYCLE + g)*AES_BYTE_W +: AES_BYTE_W];
        end
    end

    generate
        for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
            inv_sbox u_inv_sbox (
                .i_byte (w_sb_in[g]),
                .o_byte (w_sb_out[g])
            );
        end
    endgenerate

    always_comb begin
        w_work_nxt = r_work;
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            w_work_nxt[(int'(r_cnt) * BYTES_PER_CYCLE + g)*AES_BYTE_W +: AES_BYTE_W] = w_sb_out[g];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = BUSY;
            BUSY:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs are registered copies of the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_work      <= '0;
            r_out_state <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt == BUSY);
            r_out_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_work <= w_cap;
                r_cnt  <= '0;
            end else if (r_state == BUSY) begin
                r_work <= w_work_nxt;
                r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_out_state <= w_work_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: directed table, handshake corner sequences, random blocks vs a GF(2^8) model.
// Build with +define+INV_SUB_BYTES_FUSED_SHIFT_EN to exercise the fused permutation variant.
module tb_inv_sub_bytes_iter;

    localparam int NCYC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] inv_tab [256];

    typedef struct {
        string        name;
        logic [0:127] din;
        logic [0:127] dexp;
        int           stall;
    } vec_t;

    vec_t tbl [4];

    inv_sub_bytes_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward S-box from the field inverse plus affine map, then inverted into a lookup.
    task automatic build_inv_tab();
        logic [7:0] inv, s, x8;
        for (int x = 0; x < 256; x++) begin
            x8  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x8 != 8'h00 && gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
            inv_tab[s] = x8;
        end
    endtask

    function automatic logic [0:127] ref_model(input logic [0:127] s);
        logic [7:0]   st [4][4];
        logic [7:0]   sh [4][4];
        logic [0:127] r;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) st[rw][c] = s[(4*c + rw)*8 +: 8];
        for (int rw = 0; rw < 4; rw++)
            for (int c = 0; c < 4; c++) begin
`ifdef INV_SUB_BYTES_FUSED_SHIFT_EN
                sh[rw][(c + rw) % 4] = st[rw][c];
`else
                sh[rw][c] = st[rw][c];
`endif
            end
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) r[(4*c + rw)*8 +: 8] = inv_tab[sh[rw][c]];
        return r;
    endfunction

    function automatic logic [0:127] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Presents din, checks acceptance, latency, result, stall stability and return to IDLE.
    task automatic run_block(input string nm, input logic [0:127] din, input logic [0:127] dexp,
                             input int stall);
        int t;
        int lat;
        logic [0:127] held;
        in_state  = din;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({nm, " accept_wait"}, 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_state = rand_state();
        check({nm, " in_ready_drop"}, 128'(in_ready), 128'(0));
        check({nm, " busy"}, 128'(busy), 128'(1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, 128'(lat), 128'(NCYC));
        check({nm, " result"}, out_state, dexp);
        held = out_state;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({nm, " stall_hold"}, {out_valid, in_ready, busy, out_state == held}, 4'b1001);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " release"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic reset_mid_busy();
        bit seen;
        logic [0:127] d;
        d = rand_state();
        in_state  = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst state", {out_valid, in_ready, busy}, 3'b010);
        check("midrst out_state", out_state, 128'h0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst no_output", 128'(seen), 128'(0));
        d = rand_state();
        run_block("post_rst", d, ref_model(d), 1);
    endtask

    task automatic back_to_back();
        logic [0:127] a, b;
        logic [0:127] exp_q [$];
        int acc_cyc [2];
        int out_cyc [2];
        int acc;
        int nout;
        a = rand_state();
        b = rand_state();
        exp_q.push_back(ref_model(a));
        exp_q.push_back(ref_model(b));
        in_state  = a;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc  = 0;
        nout = 0;
        for (int c = 0; c < 40 && nout < 2; c++) begin
            if (out_valid) begin
                check("b2b result", out_state, exp_q.pop_front());
                out_cyc[nout] = c;
                nout++;
            end
            if (in_valid && in_ready && acc < 2) begin
                acc_cyc[acc] = c;
                acc++;
            end
            @(negedge clk);
            if (acc == 1) in_state = b;
            if (acc == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("b2b counts", {8'(acc), 8'(nout)}, {8'd2, 8'd2});
        if (acc == 2 && nout == 2) begin
            check("b2b accept_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NCYC + 2));
            check("b2b result_spacing", 128'(out_cyc[1] - out_cyc[0]), 128'(NCYC + 2));
        end
    endtask

    initial begin
        logic [0:127] d;
        build_inv_tab();

        tbl[0] = '{"all63", {16{8'h63}}, {16{8'h00}}, 0};
        tbl[1] = '{"all00_stall", {16{8'h00}}, {16{8'h52}}, 5};
`ifdef INV_SUB_BYTES_FUSED_SHIFT_EN
        tbl[2] = '{"order", {8'h7c, {14{8'h63}}, 8'hed}, {8'h01, {10{8'h00}}, 8'h53, {4{8'h00}}}, 0};
        tbl[3] = '{"row1_byte", {8'h63, 8'h00, {14{8'h63}}}, {{5{8'h00}}, 8'h52, {10{8'h00}}}, 1};
`else
        tbl[2] = '{"order", {8'h7c, {14{8'h63}}, 8'hed}, {8'h01, {14{8'h00}}, 8'h53}, 0};
        tbl[3] = '{"row1_byte", {8'h63, 8'h00, {14{8'h63}}}, {8'h00, 8'h52, {14{8'h00}}}, 1};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {out_valid, in_ready, busy}, 3'b010);
        check("reset out_state", out_state, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_block(tbl[i].name, tbl[i].din, tbl[i].dexp, tbl[i].stall);
        end

        reset_mid_busy();
        back_to_back();

        for (int i = 0; i < 16; i++) begin
            d = rand_state();
            run_block("random", d, ref_model(d), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
